multi_debouncer: RTL and testbench
==================================

Name: multi_debouncer

Overview:
Multi-channel, counter-based debouncer. It is the parametrised successor of the shift-register debouncer. Each channel filters its own input independently and qualifies both rising and falling transitions against a programmable stability window. Each channel also provides one-cycle edge strobes and a per-channel busy flag. It sits between pushbutton/sensor pads and the control FSMs: the FSMs consume clean levels or edge pulses directly, so they need no local edge detectors.

Parameters:
WIDTH, 1, number of independent channels (>=1)
STABLE_CYCLES, 4, consecutive enabled cycles an input must differ from clean_out before clean_out follows it (>=1)
RESET_VALUE, '0, WIDTH-bit per-channel value of clean_out during and after reset
CNT_W (localparam), max(1, $clog2(STABLE_CYCLES)), per-channel counter width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
en  input  1  sample enable (tie 1 for every-cycle sampling, or drive from a tick generator)
noisy_in  input  WIDTH  raw inputs
clean_out  output  WIDTH  debounced levels
rise  output  WIDTH  one-cycle strobe, channel's clean_out went 0->1
fall  output  WIDTH  one-cycle strobe, channel's clean_out went 1->0
busy  output  WIDTH  channel counter non-zero (transition being qualified)

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - clean_out = RESET_VALUE
  - all counters = 0
  - rise = fall = busy = 0
- Per channel i, sample s = noisy_in[i] (or synchronised copy, see Optional Feature).
- Two implicit states per channel, derived from the counter.
- STABLE (cnt==0): on an enabled edge, if s == clean_out[i], stay. If s != clean_out[i]:
  - STABLE_CYCLES==1: flip clean_out immediately.
  - Otherwise: cnt <= 1, go to QUALIFY.
- QUALIFY (cnt!=0), on each enabled edge:
  - s == clean_out[i]: cnt <= 0, back to STABLE. This is a glitch; no output change.
  - s != clean_out[i] and cnt == STABLE_CYCLES-1: clean_out[i] <= s, cnt <= 0.
  - otherwise: cnt <= cnt+1.
- Latency: clean_out changes on the STABLE_CYCLES-th consecutive enabled edge at which s differs from clean_out.
- en=0:
  - counters and clean_out hold; the input is not sampled.
  - rise/fall = 0 on that cycle.
  - busy reflects the held counter.
- rise[i]/fall[i] are registered and update on the same edge as clean_out[i]. They are high for exactly one cycle, the first cycle clean_out[i] shows its new value.
- Back-to-back transitions cannot produce adjacent strobes on the same channel: the minimum spacing is STABLE_CYCLES enabled edges.
- busy[i] = (cnt != 0), combinational from the registered counter.
- Channels are fully independent. Simultaneous transitions on any subset of channels update on the same edge.
- Counter never exceeds STABLE_CYCLES-1; no wrap-around.
- Reset asserted mid-qualification discards the partial count. After release, qualification restarts from RESET_VALUE.

Optional Feature:
Macro: DEBOUNCER_SYNC_EN
- Defined:
  - noisy_in passes through a 2-flop synchroniser per channel before the counter logic.
  - The synchroniser flops reset asynchronously to RESET_VALUE and clock every cycle, independent of en.
  - Adds exactly 2 clk cycles to every latency above.
- Not defined:
  - noisy_in feeds the counter logic directly; it must already be synchronous to clk.
  - No additional flops.

Test Plan:
1. Hold rst=0 with no clock edges, RESET_VALUE=4'b0101, WIDTH=4 -> clean_out=4'b0101, rise=fall=busy=0 immediately. Release rst, hold noisy_in=4'b0101 for 20 cycles -> no strobes, busy=0.
2. WIDTH=4, STABLE_CYCLES=8, en=1, noisy_in[0] 0->1 held -> busy[0]=1 for 7 cycles. On the 8th edge, clean_out[0]=1 and rise[0]=1 for one cycle. Then busy[0]=0.
3. noisy_in[1] high for 7 cycles then low -> clean_out[1] stays 0, no rise[1], busy[1] drops the cycle after the input returns low.
4. Same edge: noisy_in[2] 0->1 and noisy_in[3] 1->0, both held -> after 8 edges clean_out[2]=1, clean_out[3]=0, with rise[2] and fall[3] on the same cycle.
5. noisy_in[0] changes, en=1 for 4 edges, en=0 for 5 edges, en=1 again -> clean_out updates on the 4th re-enabled edge (8 enabled edges total). Strobes are 0 while en=0.
6. Reset mid-qualification (cnt=5): rst=0 asynchronously -> outputs back to RESET_VALUE without a clock edge. After release, a full 8 edges are again required to change. With DEBOUNCER_SYNC_EN defined, rerun scenario 2 -> update on the 10th edge.

Source files
------------

// File: rtl/multi_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : multi_debouncer
// Description : Multi-channel counter-based debouncer with per-channel edge
//               strobes and busy flags. Define DEBOUNCER_SYNC_EN to insert a
//               2-flop input synchroniser per channel.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_debouncer #(
    parameter int               WIDTH         = 1,
    parameter int               STABLE_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] noisy_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] busy
);

    localparam int               CNT_W  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(STABLE_CYCLES - 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic             w_sample;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             clean_q, clean_d;
        logic             rise_q, rise_d;
        logic             fall_q, fall_d;

`ifdef DEBOUNCER_SYNC_EN
        logic [1:0] sync_q;

        // Free-running synchroniser, deliberately not gated by en.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync_q <= {2{RESET_VALUE[i]}};
            end else begin
                sync_q <= {sync_q[0], noisy_in[i]};
            end
        end

        assign w_sample = sync_q[1];
`else
        assign w_sample = noisy_in[i];
`endif

        // A count of zero is the stable state; reaching C_LAST while the
        // sample still differs commits the new level.
        always_comb begin
            cnt_d   = cnt_q;
            clean_d = clean_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            if (en) begin
                if (w_sample != clean_q) begin
                    if (cnt_q == C_LAST) begin
                        cnt_d   = '0;
                        clean_d = w_sample;
                        rise_d  = w_sample;
                        fall_d  = ~w_sample;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q   <= '0;
                clean_q <= RESET_VALUE[i];
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                clean_q <= clean_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        assign clean_out[i] = clean_q;
        assign rise[i]      = rise_q;
        assign fall[i]      = fall_q;
        assign busy[i]      = (cnt_q != '0);
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_debouncer
// Description : Directed, table-driven bench for multi_debouncer
//               (WIDTH=4, STABLE_CYCLES=8, RESET_VALUE=4'b0101).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_debouncer;

    localparam int         WIDTH  = 4;
    localparam int         STABLE = 8;
    localparam logic [3:0] RSTV   = 4'b0101;

    typedef struct {
        int         tag;
        logic       en;
        logic [3:0] noisy;
        logic [3:0] clean;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] noisy_in;
    logic [3:0] clean_out, rise, fall, busy;

    int   total = 0;
    int   bad   = 0;
    vec_t tbl[64];
    int   n = 0;

    multi_debouncer #(
        .WIDTH        (WIDTH),
        .STABLE_CYCLES(STABLE),
        .RESET_VALUE  (RSTV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .noisy_in (noisy_in),
        .clean_out(clean_out),
        .rise     (rise),
        .fall     (fall),
        .busy     (busy)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check(input string name, input int idx,
                         input logic [3:0] ec, input logic [3:0] er,
                         input logic [3:0] ef, input logic [3:0] eb);
        total++;
        if (clean_out !== ec || rise !== er || fall !== ef || busy !== eb) begin
            bad++;
            $display("FAIL %s[%0d]: got clean=%b rise=%b fall=%b busy=%b, want clean=%b rise=%b fall=%b busy=%b",
                     name, idx, clean_out, rise, fall, busy, ec, er, ef, eb);
        end
    endtask

    task automatic add(input int tag, input logic e, input logic [3:0] nz,
                       input logic [3:0] c, input logic [3:0] r,
                       input logic [3:0] f, input logic [3:0] b);
        tbl[n] = '{tag, e, nz, c, r, f, b};
        n++;
    endtask

    initial begin
        // Channel 1 rises after 8 enabled edges.
        for (int k = 0; k < 7; k++) add(2, 1'b1, 4'b0111, 4'b0101, 4'b0000, 4'b0000, 4'b0010);
        add(2, 1'b1, 4'b0111, 4'b0111, 4'b0010, 4'b0000, 4'b0000);
        add(2, 1'b1, 4'b0111, 4'b0111, 4'b0000, 4'b0000, 4'b0000);
        // Channel 3 glitch of 7 cycles is rejected.
        for (int k = 0; k < 7; k++) add(3, 1'b1, 4'b1111, 4'b0111, 4'b0000, 4'b0000, 4'b1000);
        add(3, 1'b1, 4'b0111, 4'b0111, 4'b0000, 4'b0000, 4'b0000);
        add(3, 1'b1, 4'b0111, 4'b0111, 4'b0000, 4'b0000, 4'b0000);
        // Channels 2 (fall) and 3 (rise) change together.
        for (int k = 0; k < 7; k++) add(4, 1'b1, 4'b1011, 4'b0111, 4'b0000, 4'b0000, 4'b1100);
        add(4, 1'b1, 4'b1011, 4'b1011, 4'b1000, 4'b0100, 4'b0000);
        add(4, 1'b1, 4'b1011, 4'b1011, 4'b0000, 4'b0000, 4'b0000);
        // Channel 0 falls with an en=0 gap in the middle of qualification.
        for (int k = 0; k < 4; k++) add(5, 1'b1, 4'b1010, 4'b1011, 4'b0000, 4'b0000, 4'b0001);
        for (int k = 0; k < 5; k++) add(5, 1'b0, 4'b1010, 4'b1011, 4'b0000, 4'b0000, 4'b0001);
        for (int k = 0; k < 3; k++) add(5, 1'b1, 4'b1010, 4'b1011, 4'b0000, 4'b0000, 4'b0001);
        add(5, 1'b1, 4'b1010, 4'b1010, 4'b0000, 4'b0001, 4'b0000);
        add(5, 1'b0, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 4'b0000);

        // Asynchronous reset with the clock stopped.
        rst      = 1'b1;
        en       = 1'b1;
        noisy_in = RSTV;
        #1 rst = 1'b0;
        #2 check("reset_noclk", 0, RSTV, 4'b0000, 4'b0000, 4'b0000);
        #1 rst = 1'b1;
        clk_run = 1'b1;

        // Input equal to the reset value: nothing should move.
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            check("idle", k, RSTV, 4'b0000, 4'b0000, 4'b0000);
        end

        for (int k = 0; k < n; k++) begin
            en       = tbl[k].en;
            noisy_in = tbl[k].noisy;
            @(posedge clk); #1;
            check($sformatf("tbl_t%0d", tbl[k].tag), k,
                  tbl[k].clean, tbl[k].rise, tbl[k].fall, tbl[k].busy);
        end

        // Reset in the middle of a qualification discards the partial count.
        en       = 1'b1;
        noisy_in = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("pre_rst", k, 4'b1010, 4'b0000, 4'b0000, 4'b0001);
        end
        #1 rst = 1'b0;
        #1 check("rst_mid", 0, RSTV, 4'b0000, 4'b0000, 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= STABLE; k++) begin
            @(posedge clk); #1;
            if (k < STABLE)
                check("post_rst", k, RSTV, 4'b0000, 4'b0000, 4'b1110);
            else
                check("post_rst", k, 4'b1011, 4'b1010, 4'b0100, 4'b0000);
        end
        @(posedge clk); #1;
        check("post_rst_done", 0, 4'b1011, 4'b0000, 4'b0000, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
